// File: rtl/tiler_pkg.sv
// Shared types and widths for the point-cloud tiler frame scheduler.
// Holds the scheduler state encoding plus the cloud and frame-counter widths.
package tiler_pkg;

  localparam int CLOUD_W     = 512;
  localparam int FRAME_CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    START,
    READ,
    DRAIN,
    DONE,
    ERR,
    FLUSH
  } state_t;

endpackage

// File: rtl/tiler_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, cyclically.
// The pointer register is owned by the instantiating scheduler.
module tiler_rr_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int SRC_W   = 2
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [SRC_W-1:0]   ptr,
  output logic [NUM_SRC-1:0] grant,
  output logic [SRC_W-1:0]   idx,
  output logic               any
);

  int cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = 0;
    for (int i = 0; i < NUM_SRC; i++) begin
      cand = (int'(ptr) + i) % NUM_SRC;
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = SRC_W'(cand);
      end
    end
  end

endmodule

// File: rtl/tiler_frame_scheduler.sv
// Shares one tiling pipeline between NUM_SRC LiDAR frame sources.
// Optional frame watchdog and ERR path enabled by defining TILER_WATCHDOG_EN.
//
// state | meaning
// IDLE  | no owner; arbitrate pending requests
// GRANT | owner, cloud word and pointer latched; grant visible
// START | one-cycle tiler_start pulse
// READ  | waiting for tiler_rd_done
// DRAIN | waiting for tiler_valid
// DONE  | src_done pulse to owner, frame counted
// ERR   | src_err pulse to owner (watchdog build only)
// FLUSH | FLUSH_CYCLES idle gap before the next arbitration
module tiler_frame_scheduler
  import tiler_pkg::*;
#(
  parameter int NUM_SRC      = 4,
  parameter int SRC_W        = 2,
  parameter int FLUSH_CYCLES = 4,
  parameter int TIMEOUT      = 4096
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_SRC-1:0]       src_req,
  input  logic [NUM_SRC*CLOUD_W-1:0] src_cloud,
  output logic [NUM_SRC-1:0]       src_grant,
  output logic [NUM_SRC-1:0]       src_done,
  output logic [NUM_SRC-1:0]       src_err,
  output logic                     tiler_start,
  output logic [CLOUD_W-1:0]       tiler_cloud,
  input  logic                     tiler_rd_done,
  input  logic                     tiler_valid,
  output logic                     busy,
  output logic [SRC_W-1:0]         active_src,
  output logic [FRAME_CNT_W-1:0]   frame_count
);

  state_t             state, state_nxt;
  logic [NUM_SRC-1:0] arb_grant;
  logic [SRC_W-1:0]   arb_idx;
  logic               arb_any;
  logic [SRC_W-1:0]   rr_ptr;
  logic [SRC_W-1:0]   ptr_nxt;
  logic [NUM_SRC-1:0] owner_oh;
  logic [15:0]        flush_cnt;
  logic               wd_expire;

  tiler_rr_arbiter #(
    .NUM_SRC (NUM_SRC),
    .SRC_W   (SRC_W)
  ) u_arb (
    .req   (src_req),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  assign ptr_nxt = (arb_idx == SRC_W'(NUM_SRC-1)) ? '0 : arb_idx + SRC_W'(1);

`ifdef TILER_WATCHDOG_EN
  logic [15:0] wd_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt <= '0;
    end else if (state == START) begin
      wd_cnt <= '0;
    end else if (state == READ || state == DRAIN) begin
      wd_cnt <= wd_cnt + 16'd1;
    end
  end

  // Fires on the cycle the count steps onto TIMEOUT-1, so ERR lands TIMEOUT cycles after START.
  assign wd_expire = (wd_cnt == 16'(TIMEOUT-2));
`else
  assign wd_expire = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (arb_any) state_nxt = GRANT;
      GRANT: state_nxt = START;
      START: state_nxt = READ;
      READ: begin
        if (tiler_rd_done && tiler_valid) state_nxt = DONE;
        else if (tiler_rd_done)           state_nxt = DRAIN;
        else if (wd_expire)               state_nxt = ERR;
      end
      DRAIN: begin
        if (tiler_valid)    state_nxt = DONE;
        else if (wd_expire) state_nxt = ERR;
      end
      DONE:  state_nxt = FLUSH;
      ERR:   state_nxt = FLUSH;
      FLUSH: if (flush_cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Owner, cloud and pointer are captured on the IDLE->GRANT edge so they are valid throughout GRANT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr      <= '0;
      active_src  <= '0;
      owner_oh    <= '0;
      tiler_cloud <= '0;
      frame_count <= '0;
      flush_cnt   <= '0;
    end else begin
      if (state == IDLE && arb_any) begin
        active_src  <= arb_idx;
        owner_oh    <= arb_grant;
        tiler_cloud <= src_cloud[arb_idx*CLOUD_W +: CLOUD_W];
        rr_ptr      <= ptr_nxt;
      end
      if (state == DONE) frame_count <= frame_count + FRAME_CNT_W'(1);
      if (state == DONE || state == ERR) begin
        flush_cnt <= 16'(FLUSH_CYCLES-1);
      end else if (state == FLUSH && flush_cnt != '0) begin
        flush_cnt <= flush_cnt - 16'd1;
      end
    end
  end

  assign src_grant   = (state inside {GRANT, START, READ, DRAIN, DONE}) ? owner_oh : '0;
  assign src_done    = (state == DONE) ? owner_oh : '0;
`ifdef TILER_WATCHDOG_EN
  assign src_err     = (state == ERR) ? owner_oh : '0;
`else
  assign src_err     = '0;
`endif
  assign tiler_start = (state == START);
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_tiler_frame_scheduler.sv
// Directed plus randomized bench for tiler_frame_scheduler against a frame-level reference model.
// Define TILER_WATCHDOG_EN to also exercise the timeout path with TIMEOUT=16.
module tb_tiler_frame_scheduler;

  localparam int NS = 4;
  localparam int FC = 4;
  localparam int CW = 512;

  logic              clk = 1'b0;
  logic              reset;
  logic [NS-1:0]     src_req;
  logic [NS*CW-1:0]  src_cloud;
  logic [NS-1:0]     src_grant, src_done, src_err;
  logic              tiler_start;
  logic [CW-1:0]     tiler_cloud;
  logic              tiler_rd_done, tiler_valid;
  logic              busy;
  logic [1:0]        active_src;
  logic [15:0]       frame_count;

  tiler_frame_scheduler #(
    .NUM_SRC      (NS),
    .SRC_W        (2),
    .FLUSH_CYCLES (FC)
`ifdef TILER_WATCHDOG_EN
    , .TIMEOUT    (16)
`endif
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .src_req       (src_req),
    .src_cloud     (src_cloud),
    .src_grant     (src_grant),
    .src_done      (src_done),
    .src_err       (src_err),
    .tiler_start   (tiler_start),
    .tiler_cloud   (tiler_cloud),
    .tiler_rd_done (tiler_rd_done),
    .tiler_valid   (tiler_valid),
    .busy          (busy),
    .active_src    (active_src),
    .frame_count   (frame_count)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          m_ptr  = 0;
  int          m_fc   = 0;
  logic [CW-1:0] clouds [NS];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [NS-1:0] req, input int ptr);
    for (int k = 0; k < NS; k++) begin
      if (req[(ptr + k) % NS]) return (ptr + k) % NS;
    end
    return -1;
  endfunction

  task automatic load_clouds();
    for (int s = 0; s < NS; s++) begin
      for (int w = 0; w < CW/32; w++) clouds[s][32*w +: 32] = $urandom;
      src_cloud[s*CW +: CW] = clouds[s];
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"}, CW'(src_grant), '0);
    chk({tag, "_done"},  CW'(src_done), '0);
    chk({tag, "_err"},   CW'(src_err), '0);
    chk({tag, "_start"}, CW'(tiler_start), '0);
    chk({tag, "_cloud"}, tiler_cloud, '0);
    chk({tag, "_busy"},  CW'(busy), '0);
    chk({tag, "_asrc"},  CW'(active_src), '0);
    chk({tag, "_fcnt"},  CW'(frame_count), '0);
  endtask

  // One frame starting with the DUT in IDLE and src_req already driven.
  task automatic run_frame(input int rd_wait, input int val_wait, input bit drop_req,
                           input logic [NS-1:0] next_req, input bit spur, output int w);
    logic [NS-1:0] oh;
    logic [CW-1:0] exp_cloud;
    w  = pick(src_req, m_ptr);
    oh = NS'(1) << w;
    exp_cloud = clouds[w];
    step();
    chk("grant_oh", CW'(src_grant), CW'(oh));
    chk("grant_asrc", CW'(active_src), CW'(w));
    chk("grant_nostart", CW'(tiler_start), '0);
    m_ptr = (w + 1) % NS;
    step();
    chk("start_pulse", CW'(tiler_start), CW'(1));
    chk("start_cloud", tiler_cloud, exp_cloud);
    load_clouds();
    step();
    chk("read_nostart", CW'(tiler_start), '0);
    if (drop_req) src_req[w] = 1'b0;
    repeat (rd_wait) begin
      chk("read_nodone", CW'(src_done), '0);
      step();
    end
    tiler_rd_done = 1'b1;
    tiler_valid   = (val_wait == 0);
    step();
    tiler_rd_done = 1'b0;
    tiler_valid   = 1'b0;
    if (val_wait > 0) begin
      repeat (val_wait - 1) begin
        chk("drain_nodone", CW'(src_done), '0);
        chk("drain_grant", CW'(src_grant), CW'(oh));
        step();
      end
      tiler_valid = 1'b1;
      step();
      tiler_valid = 1'b0;
    end
    chk("done_pulse", CW'(src_done), CW'(oh));
    chk("done_grant", CW'(src_grant), CW'(oh));
    chk("done_noerr", CW'(src_err), '0);
    chk("done_cloud_stable", tiler_cloud, exp_cloud);
    m_fc = (m_fc + 1) % 65536;
    src_req = next_req;
    step();
    chk("flush_fcnt", CW'(frame_count), CW'(m_fc));
    for (int f = 0; f < FC; f++) begin
      chk("flush_busy", CW'(busy), CW'(1));
      chk("flush_grant", CW'(src_grant), '0);
      chk("flush_done", CW'(src_done), '0);
      chk("flush_start", CW'(tiler_start), '0);
      if (spur) begin
        tiler_valid   = 1'($urandom);
        tiler_rd_done = 1'($urandom);
      end
      step();
    end
    tiler_valid   = 1'b0;
    tiler_rd_done = 1'b0;
    chk("idle_busy", CW'(busy), '0);
    chk("idle_fcnt", CW'(frame_count), CW'(m_fc));
  endtask

  initial begin
    int w;
    logic [NS-1:0] nr;
    reset         = 1'b0;
    src_req       = '0;
    src_cloud     = '0;
    tiler_rd_done = 1'b0;
    tiler_valid   = 1'b0;
    #1;
    chk_all_zero("rst");
    repeat (2) step();
    reset = 1'b1;

    // spurious tiler inputs while idle
    for (int i = 0; i < 3; i++) begin
      tiler_valid   = 1'b1;
      tiler_rd_done = (i == 1);
      step();
      chk("spur_idle_busy", CW'(busy), '0);
      chk("spur_idle_done", CW'(src_done), '0);
    end
    tiler_valid   = 1'b0;
    tiler_rd_done = 1'b0;
    step();
    chk("spur_idle_fcnt", CW'(frame_count), '0);

    // fairness with all sources requesting
    load_clouds();
    src_req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      run_frame(1 + i % 3, i % 2, 1'b0, (i == 7) ? 4'b0001 : 4'b1111, 1'b0, w);
      chk("fair_order", CW'(w), CW'(i % 4));
    end

    // single source with a fixed pattern
    clouds[0] = {64{8'hA5}};
    src_cloud[0 +: CW] = clouds[0];
    run_frame(2, 2, 1'b0, 4'b0010, 1'b1, w);
    chk("single_src", CW'(w), '0);

    // rd_done and valid together, spurious inputs in flush
    run_frame(1, 0, 1'b0, '0, 1'b1, w);
    chk("same_cycle_src", CW'(w), CW'(1));

    // randomized frames
    for (int i = 0; i < 12; i++) begin
      nr = (i == 11) ? 4'b0100 : NS'($urandom_range(1, 15));
      if (i == 0) src_req = NS'($urandom_range(1, 15));
      load_clouds();
      run_frame($urandom_range(0, 4), $urandom_range(0, 4), 1'($urandom), nr, 1'($urandom), w);
    end

    // reset in the middle of DRAIN on source 2
    step();
    chk("rst_mid_grant", CW'(src_grant), CW'(4'b0100));
    step();
    step();
    tiler_rd_done = 1'b1;
    step();
    tiler_rd_done = 1'b0;
    chk("rst_mid_drain_busy", CW'(busy), CW'(1));
    src_req = 4'b1001;
    #2;
    reset = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    step();
    chk("rst_mid_nodone", CW'(src_done), '0);
    reset = 1'b1;
    m_ptr = 0;
    m_fc  = 0;
    load_clouds();
    run_frame(0, 1, 1'b0, 4'b0100, 1'b0, w);
    chk("post_rst_ptr0", CW'(w), '0);
    run_frame(3, 1, 1'b0, '0, 1'b0, w);
    chk("post_rst_src2", CW'(w), CW'(2));

`ifdef TILER_WATCHDOG_EN
    src_req = 4'b0001;
    step();
    step();
    chk("wd_start", CW'(tiler_start), CW'(1));
    m_ptr = 1;
    for (int k = 1; k < 16; k++) begin
      step();
      chk("wd_noerr", CW'(src_err), '0);
    end
    step();
    chk("wd_err", CW'(src_err), CW'(4'b0001));
    chk("wd_nodone", CW'(src_done), '0);
    chk("wd_fcnt", CW'(frame_count), CW'(m_fc));
    src_req = 4'b0010;
    step();
    repeat (FC) step();
    chk("wd_idle", CW'(busy), '0);
    run_frame(0, 0, 1'b0, '0, 1'b0, w);
    chk("wd_next_src", CW'(w), CW'(1));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
